// File: rtl/usb_bus_pkg.sv
// usb_bus_pkg
// Shared definitions for the USB parallel-bus register controller:
// bus widths, strobe lane indices and the controller state encoding.
package usb_bus_pkg;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int CNT_W   = 8;

    // Lane index of each active-low strobe inside the synchroniser bank
    localparam int NUM_STB = 4;
    localparam int STB_RD  = 0;
    localparam int STB_WR  = 1;
    localparam int STB_CE  = 2;
    localparam int STB_ALE = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WR_STROBE = 2'd1,
        RD_FETCH  = 2'd2,
        RD_DRIVE  = 2'd3
    } bus_state_t;
endpackage

// File: rtl/usb_bus_if.sv
// usb_bus_if
// External USB parallel bus as seen by the controller.
//   USB_Din/USB_Addr     : bus data and address (host -> controller)
//   USB_RDn/WRn/CEn/ALEn : active-low strobes, asynchronous to clk_usb
//   USB_Dout/USB_Dout_oe : read data and tristate enable (controller -> host)
// Modports: master = host side, slave = controller side.
interface usb_bus_if;
    import usb_bus_pkg::*;

    logic [DATA_W-1:0] USB_Din;
    logic [ADDR_W-1:0] USB_Addr;
    logic              USB_RDn;
    logic              USB_WRn;
    logic              USB_CEn;
    logic              USB_ALEn;
    logic [DATA_W-1:0] USB_Dout;
    logic              USB_Dout_oe;

    modport master (
        output USB_Din, USB_Addr, USB_RDn, USB_WRn, USB_CEn, USB_ALEn,
        input  USB_Dout, USB_Dout_oe
    );

    modport slave (
        input  USB_Din, USB_Addr, USB_RDn, USB_WRn, USB_CEn, USB_ALEn,
        output USB_Dout, USB_Dout_oe
    );
endinterface

// File: rtl/usb_strobe_sync.sv
// usb_strobe_sync
// Three-flop synchroniser for one active-low asynchronous strobe with
// falling/rising edge detection.
//   clk_usb, reset_i : clock, synchronous active-high reset
//   i_async_n        : raw strobe
//   o_sync_n         : synchronised level (second flop)
//   o_fall / o_rise  : one-cycle edge pulses aligned with o_sync_n
module usb_strobe_sync (
    input  logic clk_usb,
    input  logic reset_i,
    input  logic i_async_n,
    output logic o_sync_n,
    output logic o_fall,
    output logic o_rise
);
    logic r_meta;
    logic r_sync;
    logic r_prev;
    // r_v1/r_v2 mark when r_sync holds a real post-reset sample; a falling
    // edge is only armed after the strobe has been seen inactive, so a
    // strobe held low across reset is not mistaken for a new edge.
    logic r_v1;
    logic r_v2;
    logic r_armed;

    always_ff @(posedge clk_usb) begin
        if (reset_i) begin
            r_meta  <= 1'b1;
            r_sync  <= 1'b1;
            r_prev  <= 1'b1;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_meta <= i_async_n;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_v1   <= 1'b1;
            r_v2   <= r_v1;
            if (r_v2 && r_sync)
                r_armed <= 1'b1;
        end
    end

    assign o_sync_n = r_sync;
    assign o_fall   = r_armed & r_prev & ~r_sync;
    assign o_rise   = ~r_prev & r_sync;
endmodule

// File: rtl/usb_bus_ctrl.sv
// usb_bus_ctrl
// Bridges an asynchronous USB parallel bus to a synchronous register port.
//   clk_usb, reset_i : clock, synchronous active-high reset
//   bus              : usb_bus_if.slave (strobes, address, data, read drive)
//   reg_address/reg_addrvalid : address latched on ALE with chip enable low
//   reg_bytecnt      : byte index within the burst, wraps 255 -> 0
//   reg_datao/reg_write : write data and one-cycle write pulse
//   reg_datai/reg_read  : read data and one-cycle read pulse
//   timeout_o        : one-cycle read-drive watchdog pulse
// Optional feature: define USB_BUS_TIMEOUT_EN to enable the read-drive
// watchdog (limit pTIMEOUT cycles); otherwise RD_DRIVE waits indefinitely.
module usb_bus_ctrl
    import usb_bus_pkg::*;
#(
    parameter int pTIMEOUT = 255
) (
    input  logic              clk_usb,
    input  logic              reset_i,
    usb_bus_if.slave          bus,
    output logic [ADDR_W-1:0] reg_address,
    output logic [CNT_W-1:0]  reg_bytecnt,
    output logic              reg_addrvalid,
    output logic [DATA_W-1:0] reg_datao,
    input  logic [DATA_W-1:0] reg_datai,
    output logic              reg_read,
    output logic              reg_write,
    output logic              timeout_o
);
    logic [NUM_STB-1:0] w_async_n;
    logic [NUM_STB-1:0] w_sync_n;
    logic [NUM_STB-1:0] w_fall;
    logic [NUM_STB-1:0] w_rise;

    assign w_async_n = {bus.USB_ALEn, bus.USB_CEn, bus.USB_WRn, bus.USB_RDn};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STB; gi++) begin : g_sync
            usb_strobe_sync u_sync (
                .clk_usb   (clk_usb),
                .reset_i   (reset_i),
                .i_async_n (w_async_n[gi]),
                .o_sync_n  (w_sync_n[gi]),
                .o_fall    (w_fall[gi]),
                .o_rise    (w_rise[gi])
            );
        end
    endgenerate

    // Data/address follow the same two-stage delay as the strobe sync flops,
    // so stage 2 lines up with the edge pulses.
    logic [DATA_W-1:0] r_din_s1, r_din_s2;
    logic [ADDR_W-1:0] r_addr_s1, r_addr_s2;

    bus_state_t        r_state, w_state_next;
    logic [ADDR_W-1:0] r_address;
    logic [CNT_W-1:0]  r_bytecnt;
    logic              r_addrvalid;
    logic [DATA_W-1:0] r_datao;
    logic [DATA_W-1:0] r_dout;
    logic              r_oe;
    logic              r_read;
    logic              r_write;

    logic w_sel, w_ale, w_wr_take, w_rd_take, w_rd_done, w_tmo;

`ifdef USB_BUS_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(pTIMEOUT - 1);
    logic [7:0] r_tmo_cnt;
    logic       r_timeout;
`endif

    assign w_sel = ~w_sync_n[STB_CE] & r_addrvalid;
    assign w_ale = w_fall[STB_ALE] & ~w_sync_n[STB_CE] & (r_state == IDLE) & ~w_rise[STB_CE];

    always_ff @(posedge clk_usb) begin
        if (reset_i)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_wr_take    = 1'b0;
        w_rd_take    = 1'b0;
        w_rd_done    = 1'b0;
        w_tmo        = 1'b0;
        case (r_state)
            IDLE: begin
                // Write wins when both strobes fall together
                if (w_fall[STB_WR] && w_sel) begin
                    w_wr_take    = 1'b1;
                    w_state_next = WR_STROBE;
                end else if (w_fall[STB_RD] && w_sel) begin
                    w_rd_take    = 1'b1;
                    w_state_next = RD_FETCH;
                end
            end
            WR_STROBE: w_state_next = IDLE;
            RD_FETCH:  w_state_next = RD_DRIVE;
            RD_DRIVE: begin
                if (w_rise[STB_RD]) begin
                    w_rd_done    = 1'b1;
                    w_state_next = IDLE;
                end
`ifdef USB_BUS_TIMEOUT_EN
                else if (r_tmo_cnt == TMO_LAST) begin
                    w_tmo        = 1'b1;
                    w_state_next = IDLE;
                end
`endif
            end
            default: w_state_next = IDLE;
        endcase
        // Chip-enable release aborts everything in flight
        if (w_rise[STB_CE]) begin
            w_state_next = IDLE;
            w_wr_take    = 1'b0;
            w_rd_take    = 1'b0;
            w_rd_done    = 1'b0;
            w_tmo        = 1'b0;
        end
    end

    always_ff @(posedge clk_usb) begin
        if (reset_i) begin
            r_din_s1    <= '0;
            r_din_s2    <= '0;
            r_addr_s1   <= '0;
            r_addr_s2   <= '0;
            r_address   <= '0;
            r_bytecnt   <= '0;
            r_addrvalid <= 1'b0;
            r_datao     <= '0;
            r_dout      <= '0;
            r_oe        <= 1'b0;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
        end else begin
            r_din_s1  <= bus.USB_Din;
            r_din_s2  <= r_din_s1;
            r_addr_s1 <= bus.USB_Addr;
            r_addr_s2 <= r_addr_s1;

            // A write already in WR_STROBE completes even if CE is released
            r_write <= (r_state == WR_STROBE);
            r_read  <= w_rd_take;

            if (w_wr_take)
                r_datao <= r_din_s2;

            if (r_state == RD_FETCH && !w_rise[STB_CE]) begin
                r_dout <= reg_datai;
                r_oe   <= 1'b1;
            end
            if (w_rd_done || w_tmo || w_rise[STB_CE])
                r_oe <= 1'b0;

            if (w_rise[STB_CE])
                r_addrvalid <= 1'b0;
            else if (w_ale) begin
                r_address   <= r_addr_s2;
                r_addrvalid <= 1'b1;
            end

            if (w_ale)
                r_bytecnt <= '0;
            else if (r_write || w_rd_done)
                r_bytecnt <= r_bytecnt + 1'b1;
        end
    end

`ifdef USB_BUS_TIMEOUT_EN
    always_ff @(posedge clk_usb) begin
        if (reset_i) begin
            r_tmo_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_tmo_cnt <= (r_state == RD_DRIVE) ? r_tmo_cnt + 1'b1 : 8'd0;
            r_timeout <= w_tmo;
        end
    end
    assign timeout_o = r_timeout;
    logic w_unused;
    assign w_unused = ^{w_rise[STB_WR], w_rise[STB_ALE], w_sync_n[STB_RD],
                        w_sync_n[STB_WR], w_sync_n[STB_ALE], w_fall[STB_CE]};
`else
    assign timeout_o = 1'b0;
    logic [7:0] w_unused_tmo;
    logic       w_unused;
    assign w_unused_tmo = 8'(pTIMEOUT);
    assign w_unused = ^{w_rise[STB_WR], w_rise[STB_ALE], w_sync_n[STB_RD],
                        w_sync_n[STB_WR], w_sync_n[STB_ALE], w_fall[STB_CE],
                        w_unused_tmo};
`endif

    assign bus.USB_Dout    = r_dout;
    assign bus.USB_Dout_oe = r_oe;
    assign reg_address     = r_address;
    assign reg_bytecnt     = r_bytecnt;
    assign reg_addrvalid   = r_addrvalid;
    assign reg_datao       = r_datao;
    assign reg_read        = r_read;
    assign reg_write       = r_write;
endmodule

// File: tb/tb_usb_bus_ctrl.sv
// tb_usb_bus_ctrl
// Table-driven bench for usb_bus_ctrl with a write/read pulse scoreboard.
module tb_usb_bus_ctrl;
    import usb_bus_pkg::*;

    localparam int TMO = 20;

    logic       clk_usb = 1'b0;
    logic       reset_i = 1'b1;
    logic [7:0] reg_address, reg_bytecnt, reg_datao, reg_datai;
    logic       reg_addrvalid, reg_read, reg_write, timeout_o;

    always #5 clk_usb = ~clk_usb;

    usb_bus_if bus ();

    usb_bus_ctrl #(.pTIMEOUT(TMO)) dut (
        .clk_usb       (clk_usb),
        .reset_i       (reset_i),
        .bus           (bus),
        .reg_address   (reg_address),
        .reg_bytecnt   (reg_bytecnt),
        .reg_addrvalid (reg_addrvalid),
        .reg_datao     (reg_datao),
        .reg_datai     (reg_datai),
        .reg_read      (reg_read),
        .reg_write     (reg_write),
        .timeout_o     (timeout_o)
    );

    typedef struct {
        logic [7:0] data;
        logic [7:0] cnt;
        logic [7:0] addr;
        int         c0;
    } wr_exp_t;

    typedef struct {
        logic [7:0] cnt;
        logic [7:0] addr;
    } rd_exp_t;

    typedef enum {OP_ALE, OP_WR, OP_RD, OP_WRRD} op_t;

    typedef struct {
        op_t        op;
        logic [7:0] val;
        logic [7:0] e_addr;
        logic [7:0] e_cnt;
        logic       e_valid;
        int         e_nwr;
        int         e_nrd;
    } vec_t;

    wr_exp_t    wr_q[$];
    rd_exp_t    rd_q[$];
    vec_t       vecs[8];

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         n_wr     = 0;
    int         n_rd     = 0;
    logic [7:0] m_cnt    = 8'h00;
    logic [7:0] m_addr   = 8'h00;
    logic       m_valid  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_usb);
    endtask

    initial forever begin
        @(posedge clk_usb);
        cyc++;
    end

    // Scoreboard monitor: pops one expectation per register pulse
    initial begin
        logic prev_wr;
        logic prev_rd;
        wr_exp_t we;
        rd_exp_t re;
        prev_wr = 1'b0;
        prev_rd = 1'b0;
        forever begin
            @(negedge clk_usb);
            if (reg_write) begin
                n_wr++;
                chk("wr_single_cycle", {31'd0, prev_wr}, 0);
                chk("wr_expected", {31'd0, wr_q.size() > 0}, 1);
                if (wr_q.size() > 0) begin
                    we = wr_q.pop_front();
                    $display("write addr=%02h data=%02h cnt=%02h", reg_address, reg_datao, reg_bytecnt);
                    chk("wr_datao", {24'd0, reg_datao}, {24'd0, we.data});
                    chk("wr_bytecnt", {24'd0, reg_bytecnt}, {24'd0, we.cnt});
                    chk("wr_addr", {24'd0, reg_address}, {24'd0, we.addr});
                    chk("wr_latency", cyc - we.c0, 4);
                end
            end
            if (reg_read) begin
                n_rd++;
                chk("rd_single_cycle", {31'd0, prev_rd}, 0);
                chk("rd_expected", {31'd0, rd_q.size() > 0}, 1);
                if (rd_q.size() > 0) begin
                    re = rd_q.pop_front();
                    $display("read  addr=%02h cnt=%02h", reg_address, reg_bytecnt);
                    chk("rd_bytecnt", {24'd0, reg_bytecnt}, {24'd0, re.cnt});
                    chk("rd_addr", {24'd0, reg_address}, {24'd0, re.addr});
                end
            end
            prev_wr = reg_write;
            prev_rd = reg_read;
        end
    end

    task automatic do_ale(input logic [7:0] a);
        @(negedge clk_usb);
        bus.USB_Addr = a;
        bus.USB_ALEn = 1'b0;
        idle(3);
        bus.USB_ALEn = 1'b1;
        idle(4);
        if (!bus.USB_CEn) begin
            m_addr  = a;
            m_cnt   = 8'h00;
            m_valid = 1'b1;
        end
    endtask

    task automatic do_wr(input logic [7:0] d, input bit with_rd);
        wr_exp_t e;
        @(negedge clk_usb);
        bus.USB_Din = d;
        if (m_valid) begin
            e.data = d;
            e.cnt  = m_cnt;
            e.addr = m_addr;
            e.c0   = cyc;
            wr_q.push_back(e);
        end
        bus.USB_WRn = 1'b0;
        if (with_rd) bus.USB_RDn = 1'b0;
        idle(4);
        bus.USB_WRn = 1'b1;
        bus.USB_RDn = 1'b1;
        idle(4);
        if (m_valid) m_cnt = m_cnt + 8'd1;
    endtask

    task automatic do_rd(input logic [7:0] di);
        rd_exp_t e;
        int k;
        @(negedge clk_usb);
        reg_datai = di;
        if (m_valid) begin
            e.cnt  = m_cnt;
            e.addr = m_addr;
            rd_q.push_back(e);
        end
        bus.USB_RDn = 1'b0;
        k = 0;
        while (!bus.USB_Dout_oe && k < 20) begin
            @(negedge clk_usb);
            k++;
        end
        chk("rd_oe_rise", {31'd0, bus.USB_Dout_oe}, {31'd0, m_valid});
        if (m_valid) begin
            reg_datai = ~di;   // read data must already be latched
            repeat (3) begin
                @(negedge clk_usb);
                chk("rd_dout_hold", {24'd0, bus.USB_Dout}, {24'd0, di});
                chk("rd_oe_hold", {31'd0, bus.USB_Dout_oe}, 1);
            end
        end
        bus.USB_RDn = 1'b1;
        idle(4);
        chk("rd_oe_fall", {31'd0, bus.USB_Dout_oe}, 0);
        if (m_valid) m_cnt = m_cnt + 8'd1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_oe"},      {31'd0, bus.USB_Dout_oe}, 0);
        chk({tag, "_dout"},    {24'd0, bus.USB_Dout}, 0);
        chk({tag, "_address"}, {24'd0, reg_address}, 0);
        chk({tag, "_bytecnt"}, {24'd0, reg_bytecnt}, 0);
        chk({tag, "_valid"},   {31'd0, reg_addrvalid}, 0);
        chk({tag, "_datao"},   {24'd0, reg_datao}, 0);
        chk({tag, "_read"},    {31'd0, reg_read}, 0);
        chk({tag, "_write"},   {31'd0, reg_write}, 0);
        chk({tag, "_timeout"}, {31'd0, timeout_o}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int nwr0;
        int nrd0;

        vecs[0] = '{OP_ALE,  8'h2A, 8'h2A, 8'h00, 1'b1, 0, 0};
        vecs[1] = '{OP_ALE,  8'h10, 8'h10, 8'h00, 1'b1, 0, 0};
        vecs[2] = '{OP_WR,   8'h11, 8'h10, 8'h01, 1'b1, 1, 0};
        vecs[3] = '{OP_WR,   8'h22, 8'h10, 8'h02, 1'b1, 1, 0};
        vecs[4] = '{OP_WR,   8'h33, 8'h10, 8'h03, 1'b1, 1, 0};
        vecs[5] = '{OP_RD,   8'h5A, 8'h10, 8'h04, 1'b1, 0, 1};
        vecs[6] = '{OP_WRRD, 8'h77, 8'h10, 8'h05, 1'b1, 1, 0};
        vecs[7] = '{OP_RD,   8'hC3, 8'h10, 8'h06, 1'b1, 0, 1};

        bus.USB_Din  = 8'h00;
        bus.USB_Addr = 8'h00;
        bus.USB_RDn  = 1'b1;
        bus.USB_WRn  = 1'b1;
        bus.USB_CEn  = 1'b0;
        bus.USB_ALEn = 1'b1;
        reg_datai    = 8'h00;
        reset_i      = 1'b1;
        idle(3);
        check_all_zero("reset");
        reset_i = 1'b0;
        idle(6);

        // Table-driven main function
        for (int i = 0; i < 8; i++) begin
            nwr0 = n_wr;
            nrd0 = n_rd;
            case (vecs[i].op)
                OP_ALE:  do_ale(vecs[i].val);
                OP_WR:   do_wr(vecs[i].val, 1'b0);
                OP_RD:   do_rd(vecs[i].val);
                default: do_wr(vecs[i].val, 1'b1);
            endcase
            chk($sformatf("v%0d_address", i), {24'd0, reg_address}, {24'd0, vecs[i].e_addr});
            chk($sformatf("v%0d_bytecnt", i), {24'd0, reg_bytecnt}, {24'd0, vecs[i].e_cnt});
            chk($sformatf("v%0d_valid", i), {31'd0, reg_addrvalid}, {31'd0, vecs[i].e_valid});
            chk($sformatf("v%0d_nwrite", i), n_wr - nwr0, vecs[i].e_nwr);
            chk($sformatf("v%0d_nread", i), n_rd - nrd0, vecs[i].e_nrd);
        end

        // CE release clears addrvalid; later strobes are ignored
        @(negedge clk_usb);
        bus.USB_CEn = 1'b1;
        idle(5);
        m_valid = 1'b0;
        chk("ce_rise_valid", {31'd0, reg_addrvalid}, 0);
        bus.USB_CEn = 1'b0;
        idle(5);
        nwr0 = n_wr;
        nrd0 = n_rd;
        do_wr(8'h99, 1'b0);
        do_rd(8'h44);
        chk("novalid_nwrite", n_wr - nwr0, 0);
        chk("novalid_nread", n_rd - nrd0, 0);
        chk("novalid_bytecnt", {24'd0, reg_bytecnt}, 32'h06);

        // Read drive with RDn held low
        do_ale(8'h40);
        @(negedge clk_usb);
        rd_q.push_back('{m_cnt, m_addr});
        reg_datai   = 8'hE1;
        bus.USB_RDn = 1'b0;
        k = 0;
        while (!bus.USB_Dout_oe && k < 20) begin
            @(negedge clk_usb);
            k++;
        end
        chk("hold_oe_rise", {31'd0, bus.USB_Dout_oe}, 1);
`ifdef USB_BUS_TIMEOUT_EN
        k = 0;
        while (bus.USB_Dout_oe && k < 100) begin
            @(negedge clk_usb);
            k++;
        end
        chk("tmo_cycles", k, TMO);
        chk("tmo_pulse", {31'd0, timeout_o}, 1);
        @(negedge clk_usb);
        chk("tmo_pulse_width", {31'd0, timeout_o}, 0);
        chk("tmo_bytecnt", {24'd0, reg_bytecnt}, 0);
`else
        repeat (1000) @(negedge clk_usb);
        chk("hold_oe_1000", {31'd0, bus.USB_Dout_oe}, 1);
        chk("hold_dout_1000", {24'd0, bus.USB_Dout}, 32'hE1);
        chk("hold_no_timeout", {31'd0, timeout_o}, 0);
`endif

        // Reset in the middle of the read drive, RDn still low
        @(negedge clk_usb);
        reset_i = 1'b1;
        @(negedge clk_usb);
        check_all_zero("midrd");
        idle(2);
        reset_i = 1'b0;
        m_cnt   = 8'h00;
        m_addr  = 8'h00;
        m_valid = 1'b0;
        nrd0    = n_rd;
        idle(10);
        chk("post_rst_no_read", n_rd - nrd0, 0);
        chk("post_rst_oe", {31'd0, bus.USB_Dout_oe}, 0);
        bus.USB_RDn = 1'b1;
        idle(6);

        // Byte counter wrap
        do_ale(8'h55);
        for (int i = 0; i < 255; i++)
            do_wr(8'(i), 1'b0);
        chk("wrap_bytecnt_ff", {24'd0, reg_bytecnt}, 32'hFF);
        do_wr(8'hAB, 1'b0);
        chk("wrap_bytecnt_00", {24'd0, reg_bytecnt}, 32'h00);

        idle(4);
        chk("wr_queue_drained", wr_q.size(), 0);
        chk("rd_queue_drained", rd_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/usb_bus_ctrl.md
USB_BUS_CTRL -- requirements
Module: usb_bus_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: ports clk_usb and reset_i.
REQ-002 The block SHALL have parameter pTIMEOUT, default 255, giving the read-drive watchdog limit in clk_usb cycles.
REQ-003 The block SHALL have the port clk_usb, input, 1 bit: the interface clock, with all logic on its rising edge.
REQ-004 The block SHALL have the port reset_i, input, 1 bit: the synchronous active-high reset.
REQ-005 The block SHALL have the ports USB_Din input 8 (sampled bus data), USB_Addr input 8, and USB_RDn, USB_WRn, USB_CEn, USB_ALEn inputs 1, all active-low strobes and all asynchronous to clk_usb.
REQ-006 The block SHALL have the ports USB_Dout output 8 (read data) and USB_Dout_oe output 1 (enables the top-level tristate).
REQ-007 The block SHALL have the ports reg_address output 8, reg_bytecnt output 8, reg_addrvalid output 1, reg_datao output 8, reg_datai input 8, reg_read output 1, reg_write output 1, and timeout_o output 1.

Function
REQ-008 The block SHALL synchronise RDn, WRn, CEn and ALEn through two flops, plus a third flop used for edge detection.
REQ-009 The block SHALL register USB_Din and USB_Addr in the same stage as the first sync flop and pipeline them alongside the strobes, so captured values align with the detected edge.
REQ-010 On a synchronised ALEn falling edge with CEn low, the block SHALL latch reg_address from the aligned USB_Addr, clear reg_bytecnt to 0 and set reg_addrvalid to 1.
REQ-011 States: IDLE, WR_STROBE, RD_FETCH, RD_DRIVE.
REQ-012 In IDLE, a WRn falling edge with CEn low and reg_addrvalid set SHALL load reg_datao from the aligned data and enter WR_STROBE.
REQ-013 In WR_STROBE, reg_write SHALL be high for exactly one cycle, reg_bytecnt SHALL increment on the following edge, and the state SHALL return to IDLE.
REQ-014 The reg_write latency SHALL be: asserted in the 4th cycle after the first clk_usb edge that samples raw WRn low.
REQ-015 In IDLE, an RDn falling edge with CEn low and reg_addrvalid set SHALL pulse reg_read for one cycle and enter RD_FETCH.
REQ-016 RD_FETCH SHALL last one cycle, capture reg_datai into USB_Dout, assert USB_Dout_oe, and enter RD_DRIVE.
REQ-017 RD_DRIVE SHALL hold USB_Dout and USB_Dout_oe stable until the synchronised RDn rises; it SHALL then deassert oe, increment reg_bytecnt and return to IDLE.
REQ-018 reg_bytecnt SHALL wrap from 255 to 0 without a flag.
REQ-019 When WRn and RDn falling edges are detected in the same cycle, the write SHALL be taken and the read ignored.
REQ-020 Strobes arriving while reg_addrvalid is 0 SHALL be ignored, with no pulses generated.
REQ-021 A synchronised CEn rising edge SHALL clear reg_addrvalid, deassert USB_Dout_oe and force IDLE from any state; any pending reg_write pulse SHALL still complete.
REQ-022 Edges detected while not in IDLE, other than CEn rising and RDn rising in RD_DRIVE, SHALL be dropped.

Reset
REQ-023 While reset_i is high, the block SHALL hold state=IDLE and all outputs 0 (USB_Dout=0x00, oe=0, reg_address=0, reg_bytecnt=0, reg_addrvalid=0, reg_datao=0, reg_read=0, reg_write=0, timeout_o=0), and SHALL set the sync flops to 1 (strobes inactive).
REQ-024 A reset asserted mid-transaction SHALL abort it with no strobe emitted; after release, a still-low strobe SHALL NOT be seen as a new edge.

Configuration
REQ-025 With USB_BUS_TIMEOUT_EN defined, an 8-bit counter SHALL run in RD_DRIVE; on reaching pTIMEOUT it SHALL deassert oe, pulse timeout_o for one cycle and return to IDLE without incrementing reg_bytecnt.
REQ-026 Without USB_BUS_TIMEOUT_EN, the counter SHALL be absent, timeout_o SHALL be tied 0, and RD_DRIVE SHALL wait indefinitely.

Structure
REQ-027 The state encoding and the bus-width constants (8-bit address and data) SHALL be placed in the shared package usb_bus_pkg.
REQ-028 The block SHALL use one sub-module, usb_strobe_sync: a three-flop synchroniser with falling- and rising-edge outputs, instantiated once per strobe.

Verification
REQ-029 ALE with CEn=0 and USB_Addr=0x2A -> reg_address=0x2A, reg_bytecnt=0, reg_addrvalid=1.
REQ-030 Address 0x10, then three WR pulses with data 0x11/0x22/0x33 -> three single-cycle reg_write pulses with reg_datao 0x11/0x22/0x33 and reg_bytecnt 0/1/2, each pulse 4 cycles after WRn goes low.
REQ-031 Read with reg_datai=0x5A -> one reg_read pulse, USB_Dout=0x5A with oe=1 until RDn rises, then oe=0 and reg_bytecnt+1.
REQ-032 WRn and RDn falling in the same cycle -> reg_write only, no reg_read; and a strobe with addrvalid=0 -> no pulse.
REQ-033 USB_BUS_TIMEOUT_EN with pTIMEOUT=20 and RDn held low -> oe drops and timeout_o pulses 20 cycles into RD_DRIVE; without the macro, oe is still high after 1000 cycles.
REQ-034 reset_i asserted mid-RD_DRIVE -> oe=0 on the next cycle; bytecnt=0xFF then one write -> bytecnt=0x00.
